pipe_stage_skid: RTL

- Parametrised successor to the fixed-field pipeline latches between CPU stages such as IF/ID, ID/EX and EX/MEM.
- Carries an opaque payload bus plus the PC using a valid/ready handshake instead of a hard-wired stall vector.
- Supports flush, zeroed bubble insertion, an optional 2-entry skid buffer, and a saturating bubble/stall counter for performance debug.
- Instantiated once per stage boundary; the payload is packed and unpacked by the surrounding stage logic.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_stage_skid_sat_counter.sv | 20 ++
 rtl/pipe_stage_skid.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and packing widths for the valid/ready pipeline stage registers.
// Producer and consumer stages use the same widths so their payload packing agrees.
package pipe_pkg;

    // ST_ prefix keeps the state names from colliding with the SKID parameter.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

    localparam int PC_RESET = 0;

    // Packed widths for each stage boundary.
    localparam int IF_ID_PAYLOAD_W  = 32 + 1;
    localparam int ID_EX_PAYLOAD_W  = 8 + 32 + 32 + 5 + 1 + 4 + 32 + 2;
    localparam int EX_MEM_PAYLOAD_W = 5 + 1 + 32 + 4 + 32 + 32;
    localparam int MEM_WB_PAYLOAD_W = 5 + 1 + 32;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used for the stage's bubble and stall performance counters.
// It sticks at all-ones instead of wrapping, and only clear returns it to zero.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register carrying payload and PC with a valid/ready handshake,
// flush, bubble zeroing, an optional 2-entry skid buffer and bubble/stall counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W    = 64,
    parameter int PC_W         = 32,
    parameter int SKID         = 1,
    parameter int CLEAR_BUBBLE = 1,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [PC_W-1:0]      in_pc,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [PC_W-1:0]      out_pc,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output skid_state_e          dbg_state
);

    // Handshake: an entry moves whenever valid and ready are both high at a rising
    // edge; a producer holds valid and its data stable until that edge.
    logic                 xfer_in;
    logic                 xfer_out;
    skid_state_e          state_q, state_d;
    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] main_pl_q, main_pl_d, skid_pl_q, skid_pl_d;
    logic [PC_W-1:0]      main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;

    always_comb begin
        if (SKID != 0) begin
            in_ready = !rst && (state_q != ST_SKID);
        end else begin
            in_ready = !rst && (out_ready || !valid_q);
        end
    end

    assign xfer_in     = in_valid && in_ready;
    assign xfer_out    = valid_q && out_ready;
    assign out_valid   = valid_q;
    assign out_payload = main_pl_q;
    assign out_pc      = main_pc_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d   = state_q;
        main_pl_d = main_pl_q;
        main_pc_d = main_pc_q;
        skid_pl_d = skid_pl_q;
        skid_pc_d = skid_pc_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (xfer_in) begin
                    state_d   = ST_FULL;
                    main_pl_d = in_payload;
                    main_pc_d = in_pc;
                end
            end
            ST_FULL: begin
                // Without a skid buffer in_ready implies out_ready, so xfer_in alone never happens.
                if (xfer_in && xfer_out) begin
                    main_pl_d = in_payload;
                    main_pc_d = in_pc;
                end else if (xfer_in) begin
                    state_d   = ST_SKID;
                    skid_pl_d = in_payload;
                    skid_pc_d = in_pc;
                end else if (xfer_out) begin
                    state_d = ST_EMPTY;
                    if (CLEAR_BUBBLE != 0) begin
                        main_pl_d = '0;
                        main_pc_d = '0;
                    end
                end
            end
            ST_SKID: begin
                if (xfer_out) begin
                    state_d   = ST_FULL;
                    main_pl_d = skid_pl_q;
                    main_pc_d = skid_pc_q;
                    if (CLEAR_BUBBLE != 0) begin
                        skid_pl_d = '0;
                        skid_pc_d = '0;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_BUBBLE != 0) begin
                main_pl_d = '0;
                main_pc_d = '0;
                skid_pl_d = '0;
                skid_pc_d = '0;
            end
        end
        valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            valid_q   <= 1'b0;
            main_pl_q <= '0;
            main_pc_q <= PC_W'(PC_RESET);
            skid_pl_q <= '0;
            skid_pc_q <= PC_W'(PC_RESET);
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            main_pl_q <= main_pl_d;
            main_pc_q <= main_pc_d;
            skid_pl_q <= skid_pl_d;
            skid_pc_q <= skid_pc_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (out_ready && !valid_q),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (valid_q && !out_ready),
        .count (stall_cnt)
    );

endmodule
